hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage CPU. Consumes the control/address fields of the ID_EX, EX_MEM and MEM_WB pipeline registers and drives their write-enable, bubble, flush and forwarding-select inputs. Handles load-use stalls, taken-branch flushes, EX-stage operand forwarding and multi-cycle data-memory waits with a timeout watchdog. Sits beside the datapath, between the pipeline registers and the PC/IF_ID write enables.

## Interface
- MEM_TIMEOUT, 255: maximum MEMWAIT cycles before fault; must be ≥1.
- CNT_W, 32: width of the stall-cycle counter.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ID_RSAddr_i / ID_RTAddr_i  in  5  source registers of the instruction in ID.
- ID_UsesRT_i  in  1  ID instruction reads RT as a source.
- ID_BranchTaken_i  in  1  branch resolved taken in ID.
- EX_MemRead_i  in  1  ID_EX MemRead output.
- EX_RSAddr_i / EX_RTAddr_i  in  5  ID_EX RSAddr/RTAddr outputs.
- EXM_RegWrite_i, EXM_RDAddr_i  in  1, 5  EX_MEM write-back control/destination.
- MWB_RegWrite_i, MWB_RDAddr_i  in  1, 5  MEM_WB write-back control/destination.
- MEM_Req_i  in  1  MEM-stage instruction accesses data memory.
- MEM_Ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF_ID load enable.
- IF_ID_Flush_o  out  1  IF_ID loads a NOP.
- ID_EX_Bubble_o  out  1  ID_EX loads zeroed control (RegWrite=MemWrite=MemRead=0).
- Stall_o  out  1  freeze ID_EX, EX_MEM, MEM_WB (hold contents).
- ForwardA_o / ForwardB_o  out  2  EX operand select for RS / RT.
- Fault_o  out  1  memory timeout, sticky until reset.
- StallCount_o  out  CNT_W  cycles with Stall_o or load-use stall.

## Operation
- FSM states: RUN, MEMWAIT, FAULT.
- RUN: MEM_Req_i && !MEM_Ack_i → Stall_o=1 combinationally, next MEMWAIT, timer←1. Req with Ack same cycle → no stall.
- MEMWAIT: Stall_o=1 while !MEM_Ack_i; timer increments each cycle. MEM_Ack_i → Stall_o=0 that cycle, next RUN, timer←0. Timer==MEM_TIMEOUT && !MEM_Ack_i → next FAULT.
- FAULT: Stall_o=1, PCWrite_o=0, IF_ID_Write_o=0, Fault_o=1; exit only via reset.
- Load-use: EX_MemRead_i && EX_RTAddr_i≠0 && (EX_RTAddr_i==ID_RSAddr_i || (ID_UsesRT_i && EX_RTAddr_i==ID_RTAddr_i)) → PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1.
- Branch: ID_BranchTaken_i && no load-use → IF_ID_Flush_o=1, PCWrite_o=1.
- Priority: Stall_o (memory/fault) > load-use > branch flush. While Stall_o=1: PCWrite_o=0, IF_ID_Write_o=0, Bubble=0, Flush=0 (hold, never bubble). Load-use plus taken branch → stall only; branch re-evaluates next cycle.
- Default (no hazard): PCWrite_o=1, IF_ID_Write_o=1, others 0.
- Forwarding (per operand, src = EX_RSAddr_i / EX_RTAddr_i): EXM_RegWrite_i && EXM_RDAddr_i≠0 && match → 2'b10; else MWB_RegWrite_i && MWB_RDAddr_i≠0 && match → 2'b01; else 2'b00. Computed even during stall.
- StallCount_o increments on every cycle with Stall_o=1 or load-use stall; wraps modulo 2^CNT_W.

## Timing
- All hazard/forward outputs combinational from inputs and current state; zero-cycle latency.
- State, timer, Fault_o, StallCount_o registered on clk_i rising edge.
- Reset (async, any state incl. mid-MEMWAIT): state RUN, timer 0, Fault_o=0, StallCount_o=0; while rst_i=1: PCWrite_o=0, IF_ID_Write_o=0, IF_ID_Flush_o=0, ID_EX_Bubble_o=1, Stall_o=0, ForwardA_o=ForwardB_o=2'b00.
- Memory stall length = wait cycles exactly; pipeline advances on the Ack edge.
- Fault asserted on the edge after timer reaches MEM_TIMEOUT (MEM_TIMEOUT+1 stalled cycles total).

## Structure
- Shared cpu_pkg: FSM state enum; FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
- Sub-module forward_unit (pure combinational, instantiated once per operand or once for both).

## Test plan
- Load-use: EX_MemRead=1, EX_RTAddr=5, ID_RSAddr=5 → PCWrite=0, IF_ID_Write=0, Bubble=1, StallCount +1; EX_RTAddr=0 → no stall.
- Forward priority: EXM and MWB both write r3, EX_RSAddr=3 → ForwardA=10; EXM_RegWrite=0 → 01; RDAddr=0 → 00.
- Memory wait: Req=1, Ack low 3 cycles then high → Stall_o=1 for exactly 3 cycles, RUN after, StallCount=3.
- Timeout: MEM_TIMEOUT=4, Ack never → Fault_o=1 after 5 stalled cycles, held; rst_i pulse → Fault_o=0, RUN, counters 0.
- Simultaneous: load-use + ID_BranchTaken → no flush, stall; memory stall + load-use → Bubble=0, Stall_o=1.
- Branch alone: ID_BranchTaken=1 → IF_ID_Flush=1, PCWrite=1 for one cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared FSM encodings, forward selects and hazard helper for hazard_ctrl
package hazard_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_MEMWAIT = 2'd1;
  localparam state_t ST_FAULT   = 2'd2;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;

  // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-register fields in, hazard/forward controls out
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       ID_RSAddr_i;
  logic [4:0]       ID_RTAddr_i;
  logic             ID_UsesRT_i;
  logic             ID_BranchTaken_i;
  logic             EX_MemRead_i;
  logic [4:0]       EX_RSAddr_i;
  logic [4:0]       EX_RTAddr_i;
  logic             EXM_RegWrite_i;
  logic [4:0]       EXM_RDAddr_i;
  logic             MWB_RegWrite_i;
  logic [4:0]       MWB_RDAddr_i;
  logic             MEM_Req_i;
  logic             MEM_Ack_i;

  logic             PCWrite_o;
  logic             IF_ID_Write_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Bubble_o;
  logic             Stall_o;
  logic [1:0]       ForwardA_o;
  logic [1:0]       ForwardB_o;
  logic             Fault_o;
  logic [CNT_W-1:0] StallCount_o;

  // Datapath side drives the pipeline fields and consumes the controls.
  modport master (
    output ID_RSAddr_i, ID_RTAddr_i, ID_UsesRT_i, ID_BranchTaken_i,
    output EX_MemRead_i, EX_RSAddr_i, EX_RTAddr_i,
    output EXM_RegWrite_i, EXM_RDAddr_i, MWB_RegWrite_i, MWB_RDAddr_i,
    output MEM_Req_i, MEM_Ack_i,
    input  PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, Stall_o,
    input  ForwardA_o, ForwardB_o, Fault_o, StallCount_o
  );

  modport slave (
    input  ID_RSAddr_i, ID_RTAddr_i, ID_UsesRT_i, ID_BranchTaken_i,
    input  EX_MemRead_i, EX_RSAddr_i, EX_RTAddr_i,
    input  EXM_RegWrite_i, EXM_RDAddr_i, MWB_RegWrite_i, MWB_RDAddr_i,
    input  MEM_Req_i, MEM_Ack_i,
    output PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, Stall_o,
    output ForwardA_o, ForwardB_o, Fault_o, StallCount_o
  );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// rtl/hazard_ctrl_forward_unit.sv - EX operand forward select for one source register
module hazard_ctrl_forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       exm_we,
  input  logic [4:0] exm_rd,
  input  logic       mwb_we,
  input  logic [4:0] mwb_rd,
  output logic [1:0] sel
);

  // EX_MEM holds the younger result, so it wins over MEM_WB on a double match.
  always_comb begin
    sel = FWD_NONE;
    if (exm_we && (exm_rd != 5'd0) && (exm_rd == src)) begin
      sel = FWD_EX_MEM;
    end else if (mwb_we && (mwb_rd != 5'd0) && (mwb_rd == src)) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/branch/memory-wait hazard controller with operand forwarding
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam int                TMR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_ONE = TMR_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             fault_q;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_stall;
  logic             load_use;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    mem_stall = 1'b0;
    case (state)
      ST_RUN: begin
        if (hz.MEM_Req_i && !hz.MEM_Ack_i) begin
          mem_stall = 1'b1;
          state_nxt = ST_MEMWAIT;
          timer_nxt = TMR_ONE;
        end
      end
      ST_MEMWAIT: begin
        if (hz.MEM_Ack_i) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end else begin
          mem_stall = 1'b1;
          // Timer saturates at the limit; the transition to FAULT takes over from there.
          if (timer == TMR_MAX) begin
            state_nxt = ST_FAULT;
          end else begin
            timer_nxt = timer + TMR_ONE;
          end
        end
      end
      ST_FAULT: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
        timer_nxt = '0;
      end
    endcase
  end

  assign load_use = load_use_hazard(hz.EX_MemRead_i, hz.EX_RTAddr_i,
                                    hz.ID_RSAddr_i, hz.ID_RTAddr_i, hz.ID_UsesRT_i);

  hazard_ctrl_forward_unit u_forward_unit_a (
    .src    (hz.EX_RSAddr_i),
    .exm_we (hz.EXM_RegWrite_i),
    .exm_rd (hz.EXM_RDAddr_i),
    .mwb_we (hz.MWB_RegWrite_i),
    .mwb_rd (hz.MWB_RDAddr_i),
    .sel    (fwd_a)
  );

  hazard_ctrl_forward_unit u_forward_unit_b (
    .src    (hz.EX_RTAddr_i),
    .exm_we (hz.EXM_RegWrite_i),
    .exm_rd (hz.EXM_RDAddr_i),
    .mwb_we (hz.MWB_RegWrite_i),
    .mwb_rd (hz.MWB_RDAddr_i),
    .sel    (fwd_b)
  );

  // Memory stall freezes everything (hold, never bubble); load-use beats a taken branch.
  always_comb begin
    hz.PCWrite_o      = 1'b1;
    hz.IF_ID_Write_o  = 1'b1;
    hz.IF_ID_Flush_o  = 1'b0;
    hz.ID_EX_Bubble_o = 1'b0;
    hz.Stall_o        = 1'b0;
    hz.ForwardA_o     = fwd_a;
    hz.ForwardB_o     = fwd_b;
    if (rst_i) begin
      hz.PCWrite_o      = 1'b0;
      hz.IF_ID_Write_o  = 1'b0;
      hz.ID_EX_Bubble_o = 1'b1;
      hz.ForwardA_o     = FWD_NONE;
      hz.ForwardB_o     = FWD_NONE;
    end else if (mem_stall) begin
      hz.Stall_o        = 1'b1;
      hz.PCWrite_o      = 1'b0;
      hz.IF_ID_Write_o  = 1'b0;
    end else if (load_use) begin
      hz.PCWrite_o      = 1'b0;
      hz.IF_ID_Write_o  = 1'b0;
      hz.ID_EX_Bubble_o = 1'b1;
    end else if (hz.ID_BranchTaken_i) begin
      hz.IF_ID_Flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_RUN;
      timer     <= '0;
      fault_q   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (state_nxt == ST_FAULT) begin
        fault_q <= 1'b1;
      end
      if (mem_stall || load_use) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.Fault_o      = fault_q;
  assign hz.StallCount_o = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - vector table, corner sequences and randomized model check of hazard_ctrl
module tb_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 32;
  localparam logic [9:0] RESET_OUT = 10'b0001000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hif.slave)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, br, exmr;
    logic [4:0] ex_rs, ex_rt;
    logic       exm_we;
    logic [4:0] exm_rd;
    logic       mwb_we;
    logic [4:0] mwb_rd;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[12];

  int          checks = 0;
  int          errors = 0;
  int          waited = 0;
  bit          m_fault = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int          fault_age = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_comb();
    return {hif.PCWrite_o, hif.IF_ID_Write_o, hif.IF_ID_Flush_o, hif.ID_EX_Bubble_o,
            hif.Stall_o, hif.ForwardA_o, hif.ForwardB_o, hif.Fault_o};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (hif.EXM_RegWrite_i && hif.EXM_RDAddr_i != 0 && hif.EXM_RDAddr_i == src) return 2'b10;
    if (hif.MWB_RegWrite_i && hif.MWB_RDAddr_i != 0 && hif.MWB_RDAddr_i == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_load_use();
    return hif.EX_MemRead_i && hif.EX_RTAddr_i != 0 &&
           (hif.EX_RTAddr_i == hif.ID_RSAddr_i ||
            (hif.ID_UsesRT_i && hif.EX_RTAddr_i == hif.ID_RTAddr_i));
  endfunction

  // An access stalls from its first un-acked cycle until the ack; waited counts stalled cycles so far.
  function automatic bit m_stall();
    return m_fault || ((waited > 0 || hif.MEM_Req_i) && !hif.MEM_Ack_i);
  endfunction

  function automatic logic [9:0] m_comb();
    bit st, lu, go;
    st = m_stall();
    lu = m_load_use();
    go = !st && !lu;
    return {go, go, go && hif.ID_BranchTaken_i, !st && lu, st,
            m_fwd(hif.EX_RSAddr_i), m_fwd(hif.EX_RTAddr_i), m_fault};
  endfunction

  task automatic clear_inputs();
    hif.ID_RSAddr_i = 0; hif.ID_RTAddr_i = 0; hif.ID_UsesRT_i = 0; hif.ID_BranchTaken_i = 0;
    hif.EX_MemRead_i = 0; hif.EX_RSAddr_i = 0; hif.EX_RTAddr_i = 0;
    hif.EXM_RegWrite_i = 0; hif.EXM_RDAddr_i = 0; hif.MWB_RegWrite_i = 0; hif.MWB_RDAddr_i = 0;
    hif.MEM_Req_i = 0; hif.MEM_Ack_i = 0;
  endtask

  task automatic tick(input string name);
    bit st, lu;
    #2;
    check({name, " comb"}, 32'(dut_comb()), 32'(m_comb()));
    st = m_stall();
    lu = m_load_use();
    @(posedge clk);
    #1;
    if (st || lu) m_cnt++;
    if (!m_fault) begin
      if (st) begin
        waited++;
        if (waited >= T + 1) m_fault = 1'b1;
      end else begin
        waited = 0;
      end
    end
    check({name, " count"}, hif.StallCount_o, m_cnt);
    check({name, " fault"}, 32'(hif.Fault_o), 32'(m_fault));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    hif.EXM_RegWrite_i = 1; hif.EXM_RDAddr_i = 5'd1; hif.EX_RSAddr_i = 5'd1; hif.EX_RTAddr_i = 5'd1;
    hif.MEM_Req_i = 1;
    rst = 1'b1;
    #1;
    check("reset outputs", 32'(dut_comb()), 32'(RESET_OUT));
    check("reset count", hif.StallCount_o, 0);
    @(posedge clk);
    #1;
    check("reset held outputs", 32'(dut_comb()), 32'(RESET_OUT));
    rst = 1'b0;
    waited = 0; m_fault = 1'b0; m_cnt = '0; fault_age = 0;
    clear_inputs();
  endtask

  task automatic drive_vec(input vec_t v);
    hif.ID_RSAddr_i = v.rs; hif.ID_RTAddr_i = v.rt; hif.ID_UsesRT_i = v.uses_rt;
    hif.ID_BranchTaken_i = v.br; hif.EX_MemRead_i = v.exmr;
    hif.EX_RSAddr_i = v.ex_rs; hif.EX_RTAddr_i = v.ex_rt;
    hif.EXM_RegWrite_i = v.exm_we; hif.EXM_RDAddr_i = v.exm_rd;
    hif.MWB_RegWrite_i = v.mwb_we; hif.MWB_RDAddr_i = v.mwb_rd;
    hif.MEM_Req_i = 0; hif.MEM_Ack_i = 0;
  endtask

  initial begin
    //          rs rt uses br exmr ex_rs ex_rt exm_we exm_rd mwb_we mwb_rd  {pcw,ifw,fl,bub,st,fa,fb,flt}
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1100000000};
    vecs[1]  = '{5, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 10'b0001000000};
    vecs[2]  = '{1, 7, 1, 0, 1, 0, 7, 0, 0, 0, 0, 10'b0001000000};
    vecs[3]  = '{1, 7, 0, 0, 1, 0, 7, 0, 0, 0, 0, 10'b1100000000};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 10'b1100000000};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 10'b1110000000};
    vecs[6]  = '{5, 0, 0, 1, 1, 0, 5, 0, 0, 0, 0, 10'b0001000000};
    vecs[7]  = '{0, 0, 0, 0, 0, 3, 0, 1, 3, 1, 3, 10'b1100010000};
    vecs[8]  = '{0, 0, 0, 0, 0, 3, 0, 0, 3, 1, 3, 10'b1100001000};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10'b1100000000};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 4, 1, 4, 0, 0, 10'b1100000100};
    vecs[11] = '{0, 0, 0, 0, 0, 6, 6, 1, 2, 1, 6, 10'b1100001010};

    clear_inputs();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), 32'(dut_comb()), 32'(vecs[i].exp));
      tick($sformatf("vec%0d", i));
    end
    clear_inputs();

    // Three un-acked cycles then the ack: exactly three stalled cycles.
    do_reset();
    hif.MEM_Req_i = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("memwait stall", 32'(hif.Stall_o), 1);
      tick("memwait");
    end
    hif.MEM_Ack_i = 1;
    #1;
    check("memwait ack stall", 32'(hif.Stall_o), 0);
    tick("memwait ack");
    clear_inputs();
    #1;
    check("memwait back to run", 32'(hif.PCWrite_o), 1);
    check("memwait count", hif.StallCount_o, 3);
    tick("memwait idle");

    // Memory stall outranks load-use: hold, no bubble.
    hif.MEM_Req_i = 1;
    hif.EX_MemRead_i = 1; hif.EX_RTAddr_i = 5'd9; hif.ID_RSAddr_i = 5'd9;
    #1;
    check("memstall+loaduse bubble", 32'(hif.ID_EX_Bubble_o), 0);
    check("memstall+loaduse stall", 32'(hif.Stall_o), 1);
    tick("memstall+loaduse");
    hif.MEM_Ack_i = 1;
    tick("memstall+loaduse ack");
    clear_inputs();

    // Timeout: T+1 stalled cycles, then sticky fault until reset.
    do_reset();
    hif.MEM_Req_i = 1;
    for (int k = 0; k < T; k++) tick("timeout wait");
    check("timeout not yet", 32'(hif.Fault_o), 0);
    tick("timeout edge");
    check("timeout fault", 32'(hif.Fault_o), 1);
    hif.MEM_Ack_i = 1;
    hif.MEM_Req_i = 0;
    for (int k = 0; k < 3; k++) tick("fault held");
    check("fault sticky", 32'(hif.Fault_o), 1);
    check("fault count", hif.StallCount_o, T + 1 + 3);
    do_reset();
    check("fault cleared", 32'(hif.Fault_o), 0);
    tick("after fault reset");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      hif.ID_RSAddr_i = 5'($urandom_range(0, 3));
      hif.ID_RTAddr_i = 5'($urandom_range(0, 3));
      hif.ID_UsesRT_i = 1'($urandom_range(0, 1));
      hif.ID_BranchTaken_i = 1'($urandom_range(0, 1));
      hif.EX_MemRead_i = 1'($urandom_range(0, 1));
      hif.EX_RSAddr_i = 5'($urandom_range(0, 3));
      hif.EX_RTAddr_i = 5'($urandom_range(0, 3));
      hif.EXM_RegWrite_i = 1'($urandom_range(0, 1));
      hif.EXM_RDAddr_i = 5'($urandom_range(0, 3));
      hif.MWB_RegWrite_i = 1'($urandom_range(0, 1));
      hif.MWB_RDAddr_i = 5'($urandom_range(0, 3));
      hif.MEM_Req_i = 1'($urandom_range(0, 1));
      hif.MEM_Ack_i = ($urandom_range(0, 2) != 0);
      tick("random");
      if (m_fault) fault_age++;
      if (fault_age > 3 || $urandom_range(0, 99) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
